tick_interval_monitor: RTL and testbench
========================================

# tick_interval_monitor

Receive-side checker for the periodic enable strobes used to pace the photonic-switch sequencer, such as the 1 MHz enable derived from the 200 MHz core clock. It counts core-clock cycles between consecutive strobes and compares each interval against an expected period with a tolerance window. It declares lock after a run of good intervals and flags bad or missing strobes. It sits at the consuming end of the strobe and gates downstream switch logic on `locked`.

## Interface
- `WIDTH`, 16: interval counter width.
- `EXPECTED`, 200: nominal strobe period in clk cycles. Must satisfy 1 ≤ EXPECTED−TOL and EXPECTED+TOL+1 < 2^WIDTH.
- `TOL`, 2: allowed deviation. An interval is good iff |interval − EXPECTED| ≤ TOL.
- `LOCK_COUNT`, 4: consecutive good intervals required for lock (1..255).

Ports:
- `clk`, input, 1: 200 MHz core clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: monitor enable (level).
- `strobe`, input, 1: incoming enable strobe, one clk cycle wide per tick.
- `clr`, input, 1: synchronous clear of `err_cnt` and `miss_cnt`.
- `period`, output, WIDTH: last measured interval.
- `period_valid`, output, 1: one-cycle pulse when `period` updates.
- `locked`, output, 1: strobe stream within tolerance.
- `bad`, output, 1: one-cycle pulse on an out-of-tolerance interval.
- `miss`, output, 1: one-cycle pulse on a strobe timeout.
- `err_cnt`, output, 8: saturating count of bad intervals.
- `miss_cnt`, output, 8: saturating count of misses.

## Operation
- Interval definition: strobes at clk cycles t and t+N give interval N. The internal counter `cnt` loads 1 on the cycle after a strobe and increments each cycle. At the next strobe, interval = `cnt`.
- States:
  - IDLE: entered from reset or when `en`=0. No measurement.
  - ARM: `en`=1, waiting for the first strobe; no timeout is active.
  - RUN: measuring.
- Transitions:
  - IDLE→ARM when `en`=1.
  - ARM→RUN on a strobe. This strobe only starts timing: no `period_valid`, no goodness check.
  - RUN→ARM on a timeout.
  - Any state→IDLE when `en`=0. This has priority over every other event in the same cycle.
- In RUN, on a strobe:
  - `period`←`cnt` and `period_valid` pulses.
  - Good interval: `good_run` increments, saturating at LOCK_COUNT. `locked` is set when `good_run` reaches LOCK_COUNT.
  - Bad interval: `bad` pulses, `err_cnt` increments, `good_run`←0, `locked`←0. State stays RUN.
- Timeout: in RUN, `cnt` = EXPECTED+TOL+1 with no strobe that cycle. Response:
  - `miss` pulses and `miss_cnt` increments.
  - `good_run`←0, `locked`←0.
  - State → ARM to resynchronise.
- Strobe on the same cycle as the timeout condition: handled as a bad interval (`bad`, `err_cnt`+1). `miss` does not fire and the state stays RUN.
- Entering IDLE: `locked`←0, `good_run`←0, `cnt`←0. `period`, `err_cnt` and `miss_cnt` hold their values.
- `clr` zeroes `err_cnt` and `miss_cnt`. If `clr` coincides with an increment, the clear wins and the result is 0.
- Counters: `err_cnt` and `miss_cnt` saturate at 255. `good_run` width is ceil(log2(LOCK_COUNT+1)).

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE. `period`=0, `period_valid`=0, `locked`=0, `bad`=0, `miss`=0, `err_cnt`=0, `miss_cnt`=0. Internal `cnt` and `good_run` are 0.
- All outputs are registered.
- `period_valid`, `bad` and `locked` update on the clk edge ending the strobe cycle, so they are visible one cycle after the strobe.
- `miss` is visible one cycle after the timeout cycle.
- Lock latency from the first strobe with ideal input: (LOCK_COUNT × EXPECTED) + 1 cycles.
- `en` deassert: `locked`=0 visible on the next cycle.
- Reset asserted mid-RUN: outputs clear immediately (asynchronously). After release the block is in IDLE and needs a fresh ARM strobe.
- Back-to-back strobes (interval 1) are legal to measure and are classed as bad when EXPECTED−TOL > 1.

## Test plan
- Defaults, strobe every 200 cycles, `en`=1: `period_valid` with `period`=200 on each strobe after the first. `locked`=1 exactly one cycle after the 5th strobe. `err_cnt`=0.
- Locked stream, then one interval of 203: `bad` pulse, `err_cnt`=1, `locked`=0. Four further 200-cycle intervals relock. One interval of 198 keeps lock.
- Locked stream, strobe withheld: `miss` pulses 204 cycles after the last strobe (timeout cycle 203, visible next cycle). `miss_cnt`=1, state ARM. The next strobe only rearms.
- Strobe landing exactly at `cnt`=203: `bad`=1, `miss`=0, `err_cnt`+1, still measuring. The next 200-cycle interval is good.
- 300 bad intervals, then `clr` coincident with a bad strobe: `err_cnt` saturates at 255, then reads 0.
- `reset_n` pulsed low mid-lock, and separately `en` dropped for 10 cycles: all outputs hit their reset values or `locked`=0 immediately. Relock takes five fresh strobes.

Source files
------------

// File: rtl/tick_interval_monitor.sv
// Strobe interval checker: measures clk cycles between strobes, judges each
// interval against EXPECTED +/- TOL, declares lock after LOCK_COUNT good
// intervals in a row, and flags bad intervals and missing strobes.
module tick_interval_monitor #(
  parameter int WIDTH      = 16,
  parameter int EXPECTED   = 200,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             strobe,
  input  logic             clr,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             bad,
  output logic             miss,
  output logic [7:0]       err_cnt,
  output logic [7:0]       miss_cnt
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] LO  = WIDTH'(EXPECTED - TOL);
  localparam logic [WIDTH-1:0] HI  = WIDTH'(EXPECTED + TOL);
  // First count value that can no longer be a good interval: no strobe here
  // means the strobe is missing.
  localparam logic [WIDTH-1:0] TMO = WIDTH'(EXPECTED + TOL + 1);
  localparam logic [GW-1:0]    LC  = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gr_q, gr_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             bad_q, bad_d;
  logic             miss_q, miss_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic             err_inc, miss_inc, good;

  assign good = (cnt_q >= LO) && (cnt_q <= HI);

  // Next-state: en=0 overrides everything; a strobe coinciding with the
  // timeout count is judged as a (bad) interval, not as a miss.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gr_d     = gr_q;
    period_d = period_q;
    pv_d     = 1'b0;
    locked_d = locked_q;
    bad_d    = 1'b0;
    miss_d   = 1'b0;
    err_inc  = 1'b0;
    miss_inc = 1'b0;
    if (!en) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      gr_d     = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          // First strobe only starts timing.
          if (strobe) begin
            state_d = S_RUN;
            cnt_d   = WIDTH'(1);
          end
        end
        S_RUN: begin
          if (strobe) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            cnt_d    = WIDTH'(1);
            if (good) begin
              if (gr_q != LC) gr_d = gr_q + GW'(1);
              if (gr_d == LC) locked_d = 1'b1;
            end else begin
              bad_d    = 1'b1;
              err_inc  = 1'b1;
              gr_d     = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == TMO) begin
            miss_d   = 1'b1;
            miss_inc = 1'b1;
            gr_d     = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_ARM;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Saturating error/miss counters; clr beats a same-cycle increment.
  always_comb begin
    err_d  = err_q;
    mcnt_d = mcnt_q;
    if (clr) begin
      err_d  = '0;
      mcnt_d = '0;
    end else begin
      if (err_inc  && err_q  != 8'hFF) err_d  = err_q  + 8'd1;
      if (miss_inc && mcnt_q != 8'hFF) mcnt_d = mcnt_q + 8'd1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gr_q     <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      bad_q    <= 1'b0;
      miss_q   <= 1'b0;
      err_q    <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gr_q     <= gr_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      bad_q    <= bad_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign bad          = bad_q;
  assign miss         = miss_q;
  assign err_cnt      = err_q;
  assign miss_cnt     = mcnt_q;

endmodule

// File: tb/tb_tick_interval_monitor.sv
// Bench for tick_interval_monitor: timestamp-based reference model compared
// every cycle, directed scenarios with literal expectations, then random
// strobe streams with jitter, dropouts, back-to-back strobes, en drops, clr.
module tb_tick_interval_monitor;
  localparam int WIDTH = 16, EXP = 200, TOL = 2, LC = 4;

  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, strobe = 1'b0, clr = 1'b0;
  logic [WIDTH-1:0] period;
  logic period_valid, locked, bad, miss;
  logic [7:0] err_cnt, miss_cnt;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  tick_interval_monitor #(.WIDTH(WIDTH), .EXPECTED(EXP), .TOL(TOL), .LOCK_COUNT(LC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .strobe(strobe), .clr(clr),
    .period(period), .period_valid(period_valid), .locked(locked), .bad(bad),
    .miss(miss), .err_cnt(err_cnt), .miss_cnt(miss_cnt));

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 armed, 2 measuring. Intervals come from
  // the cycle stamp of the previous strobe; good_run is an unbounded count.
  int cyc = 0, m_mode = 0, m_last = 0, m_run = 0;
  int m_period = 0, m_pv = 0, m_locked = 0, m_bad = 0, m_miss = 0, m_err = 0, m_mcnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_run = 0; m_period = 0; m_pv = 0; m_locked = 0;
      m_bad = 0; m_miss = 0; m_err = 0; m_mcnt = 0;
    end else begin
      int n;
      cyc++;
      m_pv = 0; m_bad = 0; m_miss = 0;
      n = cyc - m_last;
      if (!en) begin
        m_mode = 0; m_run = 0; m_locked = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (strobe) begin m_mode = 2; m_last = cyc; end
      end else begin
        if (strobe) begin
          m_period = n; m_pv = 1; m_last = cyc;
          if (n >= EXP - TOL && n <= EXP + TOL) begin
            m_run++;
            m_locked = (m_run >= LC) ? 1 : 0;
          end else begin
            m_bad = 1; m_run = 0; m_locked = 0;
            if (m_err < 255) m_err++;
          end
        end else if (n == EXP + TOL + 1) begin
          m_miss = 1; m_run = 0; m_locked = 0; m_mode = 1;
          if (m_mcnt < 255) m_mcnt++;
        end
      end
      if (clr) begin m_err = 0; m_mcnt = 0; end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("period",       int'(period),       m_period);
      chk("period_valid", int'(period_valid), m_pv);
      chk("locked",       int'(locked),       m_locked);
      chk("bad",          int'(bad),          m_bad);
      chk("miss",         int'(miss),         m_miss);
      chk("err_cnt",      int'(err_cnt),      m_err);
      chk("miss_cnt",     int'(miss_cnt),     m_mcnt);
    end
  end

  // One clk cycle with the given strobe/clr values seen by the rising edge.
  task automatic step(input bit s, input bit c = 1'b0);
    strobe = s; clr = c;
    @(negedge clk); #1;
    strobe = 1'b0; clr = 1'b0;
  endtask

  // Strobe n cycles after the previous one.
  task automatic pulse_after(input int n, input bit c_last = 1'b0);
    repeat (n - 1) step(1'b0);
    step(1'b1, c_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); #1;
    chk_en = 1'b1;
    chk("rst_period", int'(period), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_cnt), 0);
    reset_n = 1'b1;
    step(1'b0);

    // Ideal stream: lock exactly one cycle after the 5th strobe.
    en = 1'b1;
    step(1'b0); step(1'b0);
    step(1'b1);
    chk("arm_no_pv", int'(period_valid), 0);
    repeat (3) pulse_after(EXP);
    chk("pre_lock", int'(locked), 0);
    chk("pv_200", int'(period_valid), 1);
    chk("period_200", int'(period), 200);
    pulse_after(EXP);
    chk("lock_5th", int'(locked), 1);
    chk("err_zero", int'(err_cnt), 0);

    // One long interval breaks lock; four good ones relock; 198 is tolerated.
    pulse_after(203);
    chk("bad_203", int'(bad), 1);
    chk("err_one", int'(err_cnt), 1);
    chk("unlock_203", int'(locked), 0);
    repeat (3) pulse_after(EXP);
    chk("relock_pending", int'(locked), 0);
    pulse_after(EXP);
    chk("relock", int'(locked), 1);
    pulse_after(198);
    chk("keep_198", int'(locked), 1);
    chk("bad_198", int'(bad), 0);

    // Withheld strobe: miss visible 204 cycles after the last strobe.
    repeat (202) step(1'b0);
    chk("no_miss_yet", int'(miss), 0);
    step(1'b0);
    chk("miss", int'(miss), 1);
    chk("miss_cnt1", int'(miss_cnt), 1);
    chk("miss_unlock", int'(locked), 0);
    repeat (20) step(1'b0);
    step(1'b1);
    chk("rearm_no_pv", int'(period_valid), 0);
    pulse_after(EXP);
    chk("rearm_pv", int'(period_valid), 1);

    // Strobe exactly at the timeout count is a bad interval, not a miss.
    pulse_after(203);
    chk("edge_bad", int'(bad), 1);
    chk("edge_miss", int'(miss), 0);
    chk("edge_err", int'(err_cnt), 2);
    pulse_after(EXP);
    chk("edge_next_good", int'(bad), 0);
    chk("edge_next_pv", int'(period_valid), 1);

    // Saturation, then clr coincident with a bad strobe.
    repeat (300) pulse_after(1);
    chk("err_sat", int'(err_cnt), 255);
    chk("period_1", int'(period), 1);
    pulse_after(1, 1'b1);
    chk("clr_bad", int'(bad), 1);
    chk("clr_wins", int'(err_cnt), 0);
    chk("clr_miss", int'(miss_cnt), 0);

    // Async reset mid-lock.
    repeat (4) pulse_after(EXP);
    chk("lock_before_rst", int'(locked), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_period", int'(period), 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    step(1'b0);
    step(1'b1);
    chk("post_rst_arm_pv", int'(period_valid), 0);
    repeat (3) pulse_after(EXP);
    chk("post_rst_pending", int'(locked), 0);
    pulse_after(EXP);
    chk("post_rst_lock", int'(locked), 1);

    // en dropped for 10 cycles: locked falls next cycle, period held.
    en = 1'b0;
    step(1'b0);
    chk("en_unlock", int'(locked), 0);
    chk("en_period_hold", int'(period), 200);
    repeat (9) step(1'b1);
    en = 1'b1;
    step(1'b0);
    step(1'b1);
    repeat (3) pulse_after(EXP);
    chk("en_relock_pending", int'(locked), 0);
    pulse_after(EXP);
    chk("en_relock", int'(locked), 1);

    // Random streams checked against the model.
    for (int k = 0; k < 60; k++) begin
      int r, n;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 7) == 0);
      if (r < 8) begin
        en = 1'b0;
        repeat ($urandom_range(1, 15)) step($urandom_range(0, 3) == 0);
        en = 1'b1;
        n = $urandom_range(2, 5);
      end else if (r < 14) n = $urandom_range(204, 260);
      else if (r < 18)     n = 1;
      else                 n = EXP + $urandom_range(0, 8) - 4;
      pulse_after(n, c);
    end
    repeat (5) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
